uart_tx_periph: RTL
===================

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 Parameter BASE_ADDR, default 10'h200, 16-byte-aligned base of the register window in data address space.
REQ-002 Parameter DEFAULT_DIV, default 16'd103, reset value of BAUDDIV; bit period = BAUDDIV+1 clk cycles.
REQ-003 Parameter FIFO_DEPTH, default 4, TX FIFO entries; power of two, minimum 2.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 address  input  10  CPU data-bus byte address.
REQ-007 data_in  input  32  CPU write data.
REQ-008 width  input  4  byte enables; bit n enables data_in[8n+7:8n].
REQ-009 write  input  1  write strobe, valid for one cycle per access.
REQ-010 data_out  output  32  registered read data.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 irq  output  1  level interrupt, high while FIFO empty and IRQ_EN set.

Function
REQ-013 Select: address[9:4] == BASE_ADDR[9:4]; register offset address[3:2]; address[1:0] ignored.
REQ-014 Offset 0 TXDATA: selected write with width[0]=1 pushes data_in[7:0] into the FIFO; reads return 0.
REQ-015 Offset 1 STATUS (read): bit0 busy (shifter not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[7:4] FIFO count; other bits 0.
REQ-016 STATUS write: width[0]=1 with data_in[3]=1 clears overflow (write-1-to-clear); other bits ignored.
REQ-017 Offset 2 BAUDDIV: R/W 16 bits; width[0] updates [7:0], width[1] updates [15:8]; reads zero-extend.
REQ-018 Offset 3 CTRL: bit0 IRQ_EN, R/W via width[0]; reset 0.
REQ-019 Read latency 1: data_out in cycle N+1 reflects register state at the cycle-N edge for the address presented in cycle N; non-selected address yields 32'h0.
REQ-020 Push to a full FIFO is dropped, FIFO unchanged, overflow set to 1.
REQ-021 Shifter FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE: txd=1; if FIFO non-empty, pop head into shift register, clear bit counter, load baud counter, go to START next cycle.
REQ-023 START: txd=0 for BAUDDIV+1 cycles, then DATA.
REQ-024 DATA: txd = shift[0], LSB first; each bit held BAUDDIV+1 cycles; after bit 7 go to STOP.
REQ-025 STOP: txd=1 for BAUDDIV+1 cycles, then IDLE; back-to-back frames add exactly one IDLE cycle between stop and next start.
REQ-026 Baud counter down-counts from BAUDDIV to 0; bit advance occurs on the cycle it equals 0.
REQ-027 BAUDDIV change mid-frame takes effect at the next counter reload; the current bit is not truncated.
REQ-028 Simultaneous push and pop in one cycle: both occur, count unchanged; allowed even when full (pop frees the slot, no overflow).
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; count is ptr-difference plus wrap bit, range 0..FIFO_DEPTH.
REQ-030 A write with width[0]=0 to TXDATA has no effect.

Reset
REQ-031 rst_n low asynchronously forces: FSM IDLE, txd=1, FIFO empty (pointers 0), overflow 0, BAUDDIV=DEFAULT_DIV, IRQ_EN 0, data_out 0, irq 0.
REQ-032 Reset mid-frame aborts the frame immediately; txd returns high without completing the stop bit.
REQ-033 After deassertion, the first write is accepted on the first rising edge with rst_n high.

Structure
REQ-034 Register offsets, STATUS bit positions and FSM state encodings live in shared include uart_defs.vh.
REQ-035 FIFO is a separate sub-module uart_tx_fifo (push, pop, wdata, rdata, full, empty, count), reused by the future receiver.
REQ-036 Top-level integration ORs data_out into the CPU read mux when the peripheral is selected.

Verification
REQ-037 BAUDDIV=3, write 0x55 to TXDATA -> txd: 4 cycles low, then 1,0,1,0,1,0,1,0 each 4 cycles, 4 cycles high; busy high throughout.
REQ-038 BAUDDIV=1, write 5 bytes back-to-back with shifter stalled (first pop occurs) -> 5th accepted only if a pop frees a slot; otherwise dropped, STATUS bit3=1; write STATUS 0x8 -> bit3=0.
REQ-039 Fill FIFO to 4 while pop occurs in same cycle as 5th push -> count stays 4, overflow stays 0.
REQ-040 Read STATUS at reset -> data_out next cycle = 0x00000004; read BAUDDIV -> 0x00000067.
REQ-041 IRQ_EN=1, send one byte -> irq low while FIFO non-empty, high in cycle after the pop empties it.
REQ-042 Assert rst_n low during DATA bit 3 -> txd=1 and STATUS empty immediately; new byte after release transmits a full correct frame.

Source files
------------

// File: rtl/uart_tx_periph_pkg.sv
// Shared UART TX definitions: register offsets, STATUS layout, shifter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_periph_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;

    localparam int STAT_OVF    = 3;
    localparam int CTRL_IRQ_EN = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Field order gives the STATUS bit positions: busy[0] full[1] empty[2] ovf[3] count[7:4].
    typedef struct packed {
        logic [3:0] count;
        logic       overflow;
        logic       empty;
        logic       full;
        logic       busy;
    } status_t;

    function automatic logic [31:0] status_word(input status_t s);
        return {24'h0, s};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with wrap-bit pointers; head is presented combinationally on rdata.
// Latency: a push is visible on rdata/count the cycle after its edge.
// Backpressure: push while full is dropped unless a pop occurs in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == DEPTH_V);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV/CTRL window, TX FIFO, shifter.
// Latency: read data one cycle after the address; an idle shifter starts the frame one cycle after the push.
// Backpressure: none toward the CPU; pushes into a full FIFO are dropped and flagged in STATUS.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR   = 10'h200,
    parameter logic [15:0] DEFAULT_DIV = 16'd103,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  width,
    input  logic        write,
    output logic [31:0] data_out,
    output logic        txd,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    offset;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          wr_ctrl;
    logic          ovf_set;

    logic [15:0]   bauddiv;
    logic          irq_en;
    logic          overflow;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [15:0]   baud_cnt;

    status_t       status;
    logic [31:0]   rd_mux;
    logic          unused_ok;

    assign sel    = (address[9:4] == BASE_ADDR[9:4]);
    assign offset = address[3:2];

    assign wr_txdata = write && sel && (offset == OFF_TXDATA) && width[0];
    assign wr_status = write && sel && (offset == OFF_STATUS) && width[0];
    assign wr_baud   = write && sel && (offset == OFF_BAUDDIV);
    assign wr_ctrl   = write && sel && (offset == OFF_CTRL) && width[0];

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign ovf_set  = wr_txdata && fifo_full && !fifo_pop;

    assign irq = irq_en && fifo_empty;

    assign unused_ok = ^{address[1:0], width[3:2], data_in[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .wdata (data_in[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Count field is 4 bits wide; depths above 8 would alias there.
    always_comb begin
        status          = '0;
        status.busy     = (state != ST_IDLE);
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.overflow = overflow;
        status.count    = 4'(fifo_count);
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_TXDATA:  rd_mux = '0;
            OFF_STATUS:  rd_mux = status_word(status);
            OFF_BAUDDIV: rd_mux = {16'h0, bauddiv};
            OFF_CTRL:    rd_mux = {31'h0, irq_en};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bauddiv  <= DEFAULT_DIV;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            data_out <= '0;
        end else begin
            // Zero when unselected so the CPU read mux can simply OR peripherals together.
            data_out <= sel ? rd_mux : '0;

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (wr_status && data_in[STAT_OVF]) begin
                overflow <= 1'b0;
            end

            if (wr_baud && width[0]) begin
                bauddiv[7:0] <= data_in[7:0];
            end
            if (wr_baud && width[1]) begin
                bauddiv[15:8] <= data_in[15:8];
            end

            if (wr_ctrl) begin
                irq_en <= data_in[CTRL_IRQ_EN];
            end
        end
    end

    // txd is driven from the same edge that changes state, so it lines up with the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_rdata;
                        bit_cnt  <= '0;
                        baud_cnt <= bauddiv;
                        txd      <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= bauddiv;
                        txd      <= shift[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= bauddiv;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        txd   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
